ifq: RTL

// Instruction fetch queue: producer end of the ifq_* interface consumed by dispatch.

---
 rtl/ifq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ifq.sv
// ifq: instruction fetch queue between the instruction cache and dispatch.
// Fetches 128-bit lines (4 x 32-bit instructions) into a line FIFO and hands
// one instruction plus its PC per cycle to dispatch. A redirect from dispatch
// flushes the queue and restarts fetch at the target.
//
// Handshake contract:
//   icache side: icache_rd_en is a request for line icache_pc. A line is
//     accepted only in a cycle where icache_rd_en and icache_dout_valid are
//     both high; a request without valid (miss) is simply repeated next cycle
//     with the same address.
//   dispatch side: ifq_empty=0 means ifq_inst/ifq_pc_out are valid. A cycle
//     with ifq_rd_en=1 and ifq_empty=0 consumes the head instruction;
//     ifq_rd_en while empty has no effect.
//   A redirect strobe overrides both sides in its cycle: neither the pop nor
//     the cache return of that cycle takes effect.
module ifq #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  icache_pc,
  output logic         icache_rd_en,
  input  logic [127:0] icache_dout,
  input  logic         icache_dout_valid,
  output logic [31:0]  ifq_pc_out,
  output logic [31:0]  ifq_inst,
  output logic         ifq_empty,
  input  logic         ifq_rd_en,
  input  logic [31:0]  ifq_jump_branch_address,
  input  logic         ifq_jump_branch_valid
);

  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_ZERO = '0;

  // Line storage and queue pointers (MSB of each pointer is the wrap bit).
  logic [127:0]      r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [1:0]        r_rd_word;
  logic [31:0]       r_fpc;
  logic [31:0]       r_rpc;

  logic              w_empty;
  logic              w_full;
  logic              w_wr_en;
  logic              w_pop;
  logic              w_pop_line;
  logic [31:0]       w_redirect_pc;
  logic [31:0]       w_fpc_next_line;
  logic [127:0]      w_head_line;

  // Queue status is derived only from registered pointers: no same-cycle bypass.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
              (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  end

  // Fetch request, write/pop qualifiers and address arithmetic.
  always_comb begin
    icache_rd_en    = rst & ~w_full & ~ifq_jump_branch_valid;
    icache_pc       = {r_fpc[31:4], 4'b0000};
    w_wr_en         = icache_rd_en & icache_dout_valid;
    w_pop           = rst & ~ifq_jump_branch_valid & ifq_rd_en & ~w_empty;
    w_pop_line      = w_pop & (r_rd_word == 2'd3);
    w_redirect_pc   = {ifq_jump_branch_address[31:2], 2'b00};
    w_fpc_next_line = {r_fpc[31:4] + 28'd1, 4'b0000};
  end

  // Head-of-queue presentation to dispatch.
  always_comb begin
    w_head_line = r_mem[r_rd_ptr[ADDR_W-1:0]];
    ifq_inst    = w_head_line[{r_rd_word, 5'b00000} +: 32];
    ifq_pc_out  = r_rpc;
    ifq_empty   = w_empty;
  end

  // Line storage: written only on an accepted cache return.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= icache_dout;
    end
  end

  // Fetch side: write pointer and fetch PC. Reset, then redirect, take priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= PTR_ZERO;
      r_fpc    <= RESET_PC;
    end else if (ifq_jump_branch_valid) begin
      r_wr_ptr <= PTR_ZERO;
      r_fpc    <= w_redirect_pc;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_fpc    <= w_fpc_next_line;
    end
  end

  // Read side: read pointer, word-in-line and read PC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr  <= PTR_ZERO;
      r_rd_word <= RESET_PC[3:2];
      r_rpc     <= RESET_PC;
    end else if (ifq_jump_branch_valid) begin
      // Refill starts line-aligned; rd_word skips words below the target.
      r_rd_ptr  <= PTR_ZERO;
      r_rd_word <= ifq_jump_branch_address[3:2];
      r_rpc     <= w_redirect_pc;
    end else if (w_pop) begin
      r_rd_word <= r_rd_word + 2'd1;
      r_rpc     <= r_rpc + 32'd4;
      if (w_pop_line) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule
